// File: rtl/pit_pkg.sv
// Shared types and helpers for the PIT modulo counter.
// Holds the default width, the count type and the effective-modulo rule.
package pit_pkg;

  localparam int COUNT_SIZE_DEF = 16;

  typedef logic [COUNT_SIZE_DEF-1:0] pit_cnt_t;

  // A modulo of zero behaves like one: every tick rolls over.
  function automatic logic [31:0] n_eff(
    input logic [31:0] m
  );
    return (m == 32'd0) ? 32'd1 : m;
  endfunction

endpackage

// File: rtl/pit_mod_shadow.sv
// Modulo shadow: pending/active pair with transfer priority.
// Writes land in pending and reach active only on a transfer strobe.
module pit_mod_shadow
  import pit_pkg::*;
#(
  parameter int                    COUNT_SIZE = COUNT_SIZE_DEF,
  parameter logic [COUNT_SIZE-1:0] MOD_RESET  = '1
) (
  input  logic                  bus_clk,
  input  logic                  sync_reset,
  input  logic                  mod_wr,
  input  logic [COUNT_SIZE-1:0] mod_value,
  input  logic                  xfer,
  output logic [COUNT_SIZE-1:0] mod_active,
  output logic                  mod_pend
);

  logic [COUNT_SIZE-1:0] pending_q, pending_d;
  logic [COUNT_SIZE-1:0] active_q, active_d;
  logic                  pend_q, pend_d;

  // A write during a transfer bypasses pending; otherwise pending moves over.
  always_comb begin
    pending_d = pending_q;
    active_d  = active_q;
    pend_d    = pend_q;
    unique case (1'b1)
      xfer && mod_wr: begin
        pending_d = mod_value;
        active_d  = mod_value;
        pend_d    = 1'b0;
      end
      xfer && !mod_wr: begin
        if (pend_q) active_d = pending_q;
        pend_d = 1'b0;
      end
      !xfer && mod_wr: begin
        pending_d = mod_value;
        pend_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Shadow registers.
  always_ff @(posedge bus_clk) begin
    if (sync_reset) begin
      pending_q <= MOD_RESET;
      active_q  <= MOD_RESET;
      pend_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
    end
  end

  assign mod_active = active_q;
  assign mod_pend   = pend_q;

endmodule

// File: rtl/pit_counter.sv
// Main PIT modulo counter: counts prescale ticks modulo a shadowed value.
// Owns the registered enable, the sticky flags and the interrupt.
module pit_counter
  import pit_pkg::*;
#(
  parameter int                    COUNT_SIZE = COUNT_SIZE_DEF,
  parameter logic [COUNT_SIZE-1:0] MOD_RESET  = '1
) (
  input  logic                  bus_clk,
  input  logic                  sync_reset,
  input  logic                  cnt_en,
  output logic                  cnt_sync_o,
  input  logic                  counter_sync,
  input  logic                  prescale_out,
  input  logic                  mod_wr,
  input  logic [COUNT_SIZE-1:0] mod_value,
  input  logic                  irq_en,
  input  logic                  flag_clr,
  output logic [COUNT_SIZE-1:0] cnt_value,
  output logic [COUNT_SIZE-1:0] mod_active,
  output logic                  mod_pend,
  output logic                  cnt_flag,
  output logic                  ovr_flag,
  output logic                  pit_irq
);

  logic [COUNT_SIZE-1:0] cnt_q, cnt_d;
  logic                  flag_q, flag_d;
  logic                  ovr_q, ovr_d;
  logic                  sync_q, sync_d;

  logic [COUNT_SIZE:0]   cnt_inc;
  logic [COUNT_SIZE:0]   n_lim;
  logic                  tick;
  logic                  roll;
  logic                  xfer;

  assign cnt_inc = {1'b0, cnt_q} + (COUNT_SIZE+1)'(1);
  assign n_lim   = (COUNT_SIZE+1)'(n_eff(32'(mod_active)));
  assign tick    = counter_sync & prescale_out;
  assign roll    = tick & (cnt_inc >= n_lim);
  assign xfer    = ~counter_sync | roll;

  pit_mod_shadow #(
    .COUNT_SIZE (COUNT_SIZE),
    .MOD_RESET  (MOD_RESET)
  ) u_shadow (
    .bus_clk    (bus_clk),
    .sync_reset (sync_reset),
    .mod_wr     (mod_wr),
    .mod_value  (mod_value),
    .xfer       (xfer),
    .mod_active (mod_active),
    .mod_pend   (mod_pend)
  );

  // Next count, flags and registered enable; rollover beats flag_clr.
  always_comb begin
    sync_d = cnt_en;
    cnt_d  = cnt_q;
    unique case (1'b1)
      !counter_sync:  cnt_d = '0;
      roll:           cnt_d = '0;
      tick && !roll:  cnt_d = cnt_inc[COUNT_SIZE-1:0];
      default: ;
    endcase
    flag_d = flag_q;
    if (roll)          flag_d = 1'b1;
    else if (flag_clr) flag_d = 1'b0;
    ovr_d = ovr_q;
    if (flag_clr)            ovr_d = 1'b0;
    else if (roll && flag_q) ovr_d = 1'b1;
  end

  // Counter state; reset overrides every other input.
  always_ff @(posedge bus_clk) begin
    if (sync_reset) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
      ovr_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      ovr_q  <= ovr_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_value  = cnt_q;
  assign cnt_flag   = flag_q;
  assign ovr_flag   = ovr_q;
  assign cnt_sync_o = sync_q;
  assign pit_irq    = flag_q & irq_en;

endmodule

// File: tb/tb_pit_counter.sv
// Scoreboard bench for pit_counter: directed vectors push expectations,
// a negedge monitor pops and compares the registered outputs.
module tb_pit_counter;
  import pit_pkg::*;

  typedef struct {
    pit_cnt_t cnt;
    pit_cnt_t act;
    logic     pend;
    logic     flag;
    logic     ovr;
    logic     sync;
  } exp_t;

  logic     bus_clk = 1'b0;
  logic     sync_reset = 1'b0;
  logic     cnt_en = 1'b0;
  logic     cnt_sync_o;
  logic     counter_sync = 1'b0;
  logic     prescale_out = 1'b0;
  logic     mod_wr = 1'b0;
  pit_cnt_t mod_value = '0;
  logic     irq_en = 1'b0;
  logic     flag_clr = 1'b0;
  pit_cnt_t cnt_value;
  pit_cnt_t mod_active;
  logic     mod_pend;
  logic     cnt_flag;
  logic     ovr_flag;
  logic     pit_irq;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   vec   = 0;

  always #5 bus_clk = ~bus_clk;

  pit_counter dut (
    .bus_clk      (bus_clk),
    .sync_reset   (sync_reset),
    .cnt_en       (cnt_en),
    .cnt_sync_o   (cnt_sync_o),
    .counter_sync (counter_sync),
    .prescale_out (prescale_out),
    .mod_wr       (mod_wr),
    .mod_value    (mod_value),
    .irq_en       (irq_en),
    .flag_clr     (flag_clr),
    .cnt_value    (cnt_value),
    .mod_active   (mod_active),
    .mod_pend     (mod_pend),
    .cnt_flag     (cnt_flag),
    .ovr_flag     (ovr_flag),
    .pit_irq      (pit_irq)
  );

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, vec, got, want);
    end
  endfunction

  // Monitor: compare the state produced by the most recent edge.
  always @(negedge bus_clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vec++;
      chk("cnt_value", 32'(cnt_value), 32'(e.cnt));
      chk("mod_active", 32'(mod_active), 32'(e.act));
      chk("mod_pend", 32'(mod_pend), 32'(e.pend));
      chk("cnt_flag", 32'(cnt_flag), 32'(e.flag));
      chk("ovr_flag", 32'(ovr_flag), 32'(e.ovr));
      chk("cnt_sync_o", 32'(cnt_sync_o), 32'(e.sync));
      chk("pit_irq", 32'(pit_irq), 32'(e.flag & irq_en));
    end
  end

  task automatic step(
    input logic     rst, en, cs, tk, wr,
    input pit_cnt_t wv,
    input logic     clr,
    input pit_cnt_t e_cnt, e_act,
    input logic     e_pend, e_flag, e_ovr, e_sync
  );
    exp_t e;
    #1;
    sync_reset   = rst;
    cnt_en       = en;
    counter_sync = cs;
    prescale_out = tk;
    mod_wr       = wr;
    mod_value    = wv;
    flag_clr     = clr;
    @(posedge bus_clk);
    e.cnt  = e_cnt;
    e.act  = e_act;
    e.pend = e_pend;
    e.flag = e_flag;
    e.ovr  = e_ovr;
    e.sync = e_sync;
    sb.push_back(e);
  endtask

  initial begin
    // rst en cs tk wr val clr | cnt act pend flag ovr sync
    step(1, 0, 0, 0, 0, 0, 0,  0, 16'hFFFF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0,  0, 5, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0,  0, 5, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  1, 5, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  2, 5, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  3, 5, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  4, 5, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  0, 5, 0, 1, 0, 1);
    irq_en = 1'b1;
    step(0, 1, 1, 1, 0, 0, 0,  1, 5, 0, 1, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  2, 5, 0, 1, 0, 1);
    step(0, 1, 1, 1, 1, 3, 0,  3, 5, 1, 1, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  4, 5, 1, 1, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0,  4, 5, 1, 1, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  0, 3, 0, 1, 1, 1);
    step(0, 1, 1, 1, 0, 0, 1,  1, 3, 0, 0, 0, 1);
    irq_en = 1'b0;
    step(0, 1, 1, 1, 0, 0, 0,  2, 3, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  0, 3, 0, 1, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  1, 3, 0, 1, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  2, 3, 0, 1, 0, 1);
    step(0, 1, 1, 1, 0, 0, 1,  0, 3, 0, 1, 0, 1);
    step(0, 1, 1, 1, 1, 0, 0,  1, 3, 1, 1, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  2, 3, 1, 1, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  0, 0, 0, 1, 1, 1);
    step(0, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    irq_en = 1'b1;
    step(0, 1, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0, 1);
    step(0, 1, 1, 1, 0, 0, 1,  0, 0, 0, 1, 0, 1);
    step(0, 1, 1, 1, 1, 1, 0,  0, 1, 0, 1, 1, 1);
    step(0, 1, 1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  0, 1, 0, 1, 0, 1);
    step(0, 1, 1, 1, 1, 5, 0,  0, 5, 0, 1, 1, 1);
    step(0, 1, 1, 1, 0, 0, 1,  1, 5, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  2, 5, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  3, 5, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 7, 0,  3, 5, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0,  0, 7, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0,  0, 7, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0,  0, 7, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  1, 7, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1, 1, 0,  0, 1, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  0, 1, 0, 1, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0,  0, 1, 0, 1, 1, 1);
    step(1, 1, 1, 1, 1, 9, 0,  0, 16'hFFFF, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0,  1, 16'hFFFF, 0, 0, 0, 1);
    #1;
    prescale_out = 1'b0;
    mod_wr       = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge bus_clk);
    @(posedge bus_clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
